blink_sequencer: RTL and testbench

BLINK_SEQUENCER -- requirements
Module: blink_sequencer

---
 rtl/blink_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_blink_sequencer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/blink_sequencer.sv
// Tick-timed LED blink sequencer: a prescaler time base drives an IDLE/ON/OFF/DONE machine.
// Optional feature: define BLINK_REPEAT_EN to add i_repeat for continuous restart.
module blink_sequencer #(
    parameter int FRECUENCY_IN = 50_000_000,
    parameter int TICK_HZ      = 10
) (
    input  logic       i_clk_FPGA,
    input  logic       i_reset,
    input  logic       i_start,
    input  logic       i_abort,
`ifdef BLINK_REPEAT_EN
    input  logic       i_repeat,
`endif
    input  logic [3:0] i_blinks,
    input  logic [3:0] i_on_ticks,
    input  logic [3:0] i_off_ticks,
    output logic       o_led,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_tick,
    output logic [3:0] o_remaining
);

    localparam int TICK_DIV = FRECUENCY_IN / TICK_HZ;
    localparam int PW       = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PRESC_ONE = PW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_OFF  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t        r_state;
    logic [PW-1:0] r_presc;
    logic [3:0]    r_phase;
    logic [3:0]    r_blinks;
    logic [3:0]    r_on_len;
    logic [3:0]    r_off_len;
    logic          r_led;
    logic          r_busy;
    logic          r_done;
    logic          r_tick;
    logic [3:0]    r_remaining;

    logic [PW-1:0] w_presc_nxt;
    logic          w_tick;
    logic          w_on_last;
    logic          w_off_last;
    logic          w_repeat;

    // A programmed duration of zero ticks behaves as a single tick
    function automatic logic [3:0] eff_ticks(input logic [3:0] v);
        eff_ticks = (v == 4'd0) ? 4'd1 : v;
    endfunction

`ifdef BLINK_REPEAT_EN
    assign w_repeat = i_repeat;
`else
    assign w_repeat = 1'b0;
`endif

    assign w_tick     = (r_presc == PRESC_MAX);
    assign w_on_last  = w_tick && (r_phase == (r_on_len - 4'd1));
    assign w_off_last = w_tick && (r_phase == (r_off_len - 4'd1));

    // Prescaler next value: runs only while blinking, otherwise parked at zero
    always_comb begin
        w_presc_nxt = '0;
        if (((r_state == S_ON) || (r_state == S_OFF)) && !i_abort) begin
            if (w_tick) begin
                w_presc_nxt = '0;
            end else begin
                w_presc_nxt = r_presc + PRESC_ONE;
            end
        end else begin
            w_presc_nxt = '0;
        end
    end

    // Sequencer state machine with registered outputs
    always_ff @(posedge i_clk_FPGA) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_presc     <= '0;
            r_phase     <= 4'd0;
            r_blinks    <= 4'd0;
            r_on_len    <= 4'd1;
            r_off_len   <= 4'd1;
            r_led       <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_tick      <= 1'b0;
            r_remaining <= 4'd0;
        end else begin
            r_presc <= w_presc_nxt;
            r_tick  <= (w_presc_nxt == PRESC_MAX);
            r_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_phase <= 4'd0;
                    r_led   <= 1'b0;
                    if (i_start && !i_abort) begin
                        r_blinks  <= i_blinks;
                        r_on_len  <= eff_ticks(i_on_ticks);
                        r_off_len <= eff_ticks(i_off_ticks);
                        r_busy    <= 1'b1;
                        if (i_blinks != 4'd0) begin
                            r_state     <= S_ON;
                            r_led       <= 1'b1;
                            r_remaining <= i_blinks - 4'd1;
                        end else begin
                            r_state     <= S_DONE;
                            r_done      <= 1'b1;
                            r_remaining <= 4'd0;
                        end
                    end else begin
                        r_busy      <= 1'b0;
                        r_remaining <= 4'd0;
                    end
                end
                S_ON: begin
                    if (i_abort) begin
                        r_state     <= S_IDLE;
                        r_phase     <= 4'd0;
                        r_led       <= 1'b0;
                        r_busy      <= 1'b0;
                        r_remaining <= 4'd0;
                    end else if (w_on_last) begin
                        r_state <= S_OFF;
                        r_phase <= 4'd0;
                        r_led   <= 1'b0;
                    end else if (w_tick) begin
                        r_phase <= r_phase + 4'd1;
                    end else begin
                        r_phase <= r_phase;
                    end
                end
                S_OFF: begin
                    if (i_abort) begin
                        r_state     <= S_IDLE;
                        r_phase     <= 4'd0;
                        r_led       <= 1'b0;
                        r_busy      <= 1'b0;
                        r_remaining <= 4'd0;
                    end else if (w_off_last) begin
                        r_phase <= 4'd0;
                        if (r_remaining != 4'd0) begin
                            r_state     <= S_ON;
                            r_led       <= 1'b1;
                            r_remaining <= r_remaining - 4'd1;
                        end else if (w_repeat) begin
                            // Restart from the latched blink count, skipping DONE
                            r_state     <= S_ON;
                            r_led       <= 1'b1;
                            r_remaining <= r_blinks - 4'd1;
                        end else begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end else if (w_tick) begin
                        r_phase <= r_phase + 4'd1;
                    end else begin
                        r_phase <= r_phase;
                    end
                end
                S_DONE: begin
                    r_state     <= S_IDLE;
                    r_phase     <= 4'd0;
                    r_led       <= 1'b0;
                    r_busy      <= 1'b0;
                    r_remaining <= 4'd0;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_phase     <= 4'd0;
                    r_led       <= 1'b0;
                    r_busy      <= 1'b0;
                    r_remaining <= 4'd0;
                end
            endcase
        end
    end

    assign o_led       = r_led;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_tick      = r_tick;
    assign o_remaining = r_remaining;

endmodule

// File: tb/tb_blink_sequencer.sv
// Self-checking bench for blink_sequencer with TICK_DIV = 4 (40 Hz clock, 10 Hz tick).
module tb_blink_sequencer;

    logic       clk;
    logic       i_reset;
    logic       i_start;
    logic       i_abort;
    logic [3:0] i_blinks;
    logic [3:0] i_on_ticks;
    logic [3:0] i_off_ticks;
    logic       o_led;
    logic       o_busy;
    logic       o_done;
    logic       o_tick;
    logic [3:0] o_remaining;
`ifdef BLINK_REPEAT_EN
    logic       i_repeat;
`endif

    int n_checks;
    int n_fail;

    blink_sequencer #(
        .FRECUENCY_IN(40),
        .TICK_HZ     (10)
    ) dut (
        .i_clk_FPGA (clk),
        .i_reset    (i_reset),
        .i_start    (i_start),
        .i_abort    (i_abort),
`ifdef BLINK_REPEAT_EN
        .i_repeat   (i_repeat),
`endif
        .i_blinks   (i_blinks),
        .i_on_ticks (i_on_ticks),
        .i_off_ticks(i_off_ticks),
        .o_led      (o_led),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_tick     (o_tick),
        .o_remaining(o_remaining)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] blinks;
        logic [3:0] on_t;
        logic [3:0] off_t;
        int         exp_done_cyc;
        int         exp_rises;
        int         exp_high;
        int         exp_ticks;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drives a start pulse; returns at the negedge of cycle 1 after the start edge
    task automatic start_seq(input logic [3:0] n, input logic [3:0] on_t, input logic [3:0] off_t);
        @(negedge clk);
        i_blinks    = n;
        i_on_ticks  = on_t;
        i_off_ticks = off_t;
        i_start     = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int   c;
        int   done_cyc;
        int   rises;
        int   highs;
        int   busys;
        int   ticks;
        logic prev_led;
        c = 1; done_cyc = 0; rises = 0; highs = 0; busys = 0; ticks = 0; prev_led = 1'b0;
        start_seq(v.blinks, v.on_t, v.off_t);
        // Inputs changed while busy must not affect the running sequence
        i_blinks    = 4'hF;
        i_on_ticks  = 4'hF;
        i_off_ticks = 4'hF;
        while (c <= 300) begin
            if (o_led && !prev_led) rises++;
            prev_led = o_led;
            highs += int'(o_led);
            busys += int'(o_busy);
            ticks += int'(o_tick);
            if (o_done) begin
                done_cyc = c;
                break;
            end
            @(negedge clk);
            c++;
        end
        check($sformatf("v%0d_done_cycle", idx), done_cyc, v.exp_done_cyc);
        check($sformatf("v%0d_led_rises", idx), rises, v.exp_rises);
        check($sformatf("v%0d_led_high_cycles", idx), highs, v.exp_high);
        check($sformatf("v%0d_busy_cycles", idx), busys, v.exp_done_cyc);
        check($sformatf("v%0d_ticks", idx), ticks, v.exp_ticks);
        @(negedge clk);
        check($sformatf("v%0d_idle_after", idx), int'({o_busy, o_done, o_led}), 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rem_seen[3];
        int dones;
        int rises;
        logic prev_led;
        n_checks = 0;
        n_fail   = 0;

        vecs[0] = '{4'd2, 4'd1, 4'd2, 25, 2, 8, 6};
        vecs[1] = '{4'd0, 4'd5, 4'd5, 1, 0, 0, 0};
        vecs[2] = '{4'd3, 4'd0, 4'd0, 25, 3, 12, 6};
        vecs[3] = '{4'd1, 4'd2, 4'd1, 13, 1, 8, 3};
        vecs[4] = '{4'd4, 4'd1, 4'd1, 33, 4, 16, 8};
        vecs[5] = '{4'd1, 4'd15, 4'd0, 65, 1, 60, 16};

        i_reset = 1'b1; i_start = 1'b0; i_abort = 1'b0;
        i_blinks = 4'd0; i_on_ticks = 4'd0; i_off_ticks = 4'd0;
`ifdef BLINK_REPEAT_EN
        i_repeat = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("reset_outputs", int'({o_led, o_busy, o_done, o_tick, o_remaining}), 0);
        i_reset = 1'b0;
        @(negedge clk);
        check("idle_outputs", int'({o_led, o_busy, o_done, o_tick, o_remaining}), 0);

        for (int i = 0; i < 6; i++) begin
            run_vec(i, vecs[i]);
        end

        // Remaining count walks 2,1,0 across the three blinks
        start_seq(4'd3, 4'd0, 4'd0);
        for (int c = 1; c <= 17; c++) begin
            if (c == 1) rem_seen[0] = int'(o_remaining);
            if (c == 9) rem_seen[1] = int'(o_remaining);
            if (c == 17) rem_seen[2] = int'(o_remaining);
            if (c < 17) @(negedge clk);
        end
        check("rem_blink1", rem_seen[0], 2);
        check("rem_blink2", rem_seen[1], 1);
        check("rem_blink3", rem_seen[2], 0);
        repeat (12) @(negedge clk);

        // Abort during the second ON of a five-blink sequence
        start_seq(4'd5, 4'd1, 4'd1);
        check("abort_rem_first_on", int'(o_remaining), 4);
        repeat (8) @(negedge clk);
        check("abort_second_on", int'({o_led, o_remaining}), int'({1'b1, 4'd3}));
        @(negedge clk);
        i_abort = 1'b1;
        @(negedge clk);
        i_abort = 1'b0;
        check("abort_outputs", int'({o_led, o_busy, o_done, o_remaining}), 0);
        dones = 0; rises = 0; prev_led = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            dones += int'(o_done);
            if (o_led && !prev_led) rises++;
            prev_led = o_led;
        end
        check("abort_no_done", dones, 0);
        check("abort_no_led", rises, 0);

        // Abort and start together in IDLE: start ignored
        i_blinks = 4'd2; i_start = 1'b1; i_abort = 1'b1;
        @(negedge clk);
        i_start = 1'b0; i_abort = 1'b0;
        check("abort_beats_start", int'({o_busy, o_done, o_led}), 0);

        // Reset mid-OFF with start also high
        start_seq(4'd2, 4'd1, 4'd2);
        repeat (5) @(negedge clk);
        check("pre_reset_off", int'({o_led, o_busy}), int'({1'b0, 1'b1}));
        i_reset = 1'b1; i_start = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("reset_mid_off_c%0d", c),
                  int'({o_led, o_busy, o_done, o_tick, o_remaining}), 0);
        end
        i_reset = 1'b0;
        @(negedge clk);
        check("start_after_reset", int'({o_led, o_busy, o_remaining}), int'({1'b1, 1'b1, 4'd1}));
        i_start = 1'b0; i_abort = 1'b1;
        @(negedge clk);
        i_abort = 1'b0;
        check("abort_cleanup", int'({o_busy, o_done}), 0);

        // Start held high: new sequence on the first IDLE cycle after DONE
        @(negedge clk);
        i_blinks = 4'd0; i_start = 1'b1;
        @(negedge clk);
        check("held_done1", int'({o_busy, o_done}), 3);
        @(negedge clk);
        check("held_idle_gap", int'({o_busy, o_done}), 0);
        @(negedge clk);
        i_start = 1'b0;
        check("held_done2", int'({o_busy, o_done}), 3);
        @(negedge clk);
        check("held_end", int'({o_busy, o_done}), 0);

`ifdef BLINK_REPEAT_EN
        // Continuous repeat: no DONE until i_repeat drops
        i_repeat = 1'b1;
        start_seq(4'd1, 4'd1, 4'd1);
        dones = 0; rises = 0; prev_led = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            dones += int'(o_done);
            if (o_led && !prev_led) rises++;
            prev_led = o_led;
            if (c < 40) @(negedge clk);
        end
        check("repeat_no_done", dones, 0);
        check("repeat_rises", rises, 5);
        i_repeat = 1'b0;
        dones = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            dones += int'(o_done);
        end
        check("repeat_stop_done", dones, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
